// File: rtl/rr_request_encoder_pkg.sv
// Shared definitions for the round-robin request encoder.
//   arb_state_e   : FSM encoding (IDLE / GRANTED)
//   MAX_REQ       : widest requester vector the helpers accept
//   PTR_RESET     : reset priority pointer, one-hot bit 0 (requester 0 first)
//   onehot_to_idx : one-hot to binary index, shared by the encoder and its bench
package rr_request_encoder_pkg;

  typedef enum logic {
    ARB_STATE_IDLE    = 1'b0,
    ARB_STATE_GRANTED = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 32;

  localparam logic [MAX_REQ-1:0] PTR_RESET = MAX_REQ'(1);

  // OR-ing the indices of the set bits is exact for a one-hot input and
  // needs no priority chain.
  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_request_encoder_if.sv
// Request/grant bundle of the round-robin request encoder.
//   master : client side, drives Enable, Request, Release
//   slave  : arbiter side, drives Grant, GrantIndex, GrantValid, Timeout
interface rr_request_encoder_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = 2
);
  logic                 Enable;
  logic [NUM_REQ-1:0]   Request;
  logic                 Release;
  logic [NUM_REQ-1:0]   Grant;
  logic [IDX_WIDTH-1:0] GrantIndex;
  logic                 GrantValid;
  logic                 Timeout;

  modport master (
    output Enable, Request, Release,
    input  Grant, GrantIndex, GrantValid, Timeout
  );

  modport slave (
    input  Enable, Request, Release,
    output Grant, GrantIndex, GrantValid, Timeout
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: returns the one-hot winner, i.e. the first
// set request bit at or above the one-hot pointer, wrapping to bit 0.
//   req_i : request vector
//   ptr_i : one-hot priority pointer
//   gnt_o : one-hot winner, zero when req_i is zero
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [2*NUM_REQ-1:0] dbl_req;
  logic [2*NUM_REQ-1:0] dbl_gnt;

  // Subtracting the pointer from the doubled vector clears the first request
  // at/above the pointer (borrowing into the upper copy to wrap); the AND with
  // the inverted difference isolates exactly that bit.
  always_comb begin
    dbl_req = {req_i, req_i};
    dbl_gnt = dbl_req & ~(dbl_req - {{NUM_REQ{1'b0}}, ptr_i});
    gnt_o   = dbl_gnt[NUM_REQ-1:0] | dbl_gnt[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/rr_request_encoder.sv
// Round-robin arbiter and encoder. Registers a one-hot grant plus its binary
// index and holds it until the owner releases (Release pulse or dropping its
// request). The pointer then rotates past the owner, so an idle cycle always
// separates grants and no requester is re-granted ahead of waiting peers.
//   Clock, Reset : clock and synchronous active-high reset
//   bus (slave)  : Enable/Request/Release in, Grant/GrantIndex/GrantValid/Timeout out
// Optional ARB_TIMEOUT_EN: a TIMEOUT_WIDTH-bit watchdog force-releases a grant
// held too long and pulses Timeout; without it Timeout is tied to 0.
// NUM_REQ must be at least 2.
module rr_request_encoder
  import rr_request_encoder_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned IDX_WIDTH     = 2,
  parameter int unsigned TIMEOUT_WIDTH = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  rr_request_encoder_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > (1 << IDX_WIDTH) || TIMEOUT_WIDTH < 1) begin : g_bad_params
    $error("rr_request_encoder: illegal parameter combination");
  end

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [NUM_REQ-1:0]   pick;
  logic                 owner_done;
  logic                 release_now;
`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic                     expire;
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i (bus.Request),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    // Explicit release and a dropped owner request fold into one event.
    owner_done  = bus.Release | ~|(bus.Request & grant_q);
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    expire      = &cnt_q;
    release_now = owner_done | expire;
`else
    release_now = owner_done;
`endif

    case (state_q)
      ARB_STATE_IDLE: begin
        if (bus.Enable && |bus.Request) begin
          state_d = ARB_STATE_GRANTED;
          grant_d = pick;
          idx_d   = IDX_WIDTH'(onehot_to_idx(MAX_REQ'(pick)));
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_STATE_GRANTED: begin
        if (release_now) begin
          state_d = ARB_STATE_IDLE;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          // Rotating the owner's one-hot gives pointer (GrantIndex+1) mod NUM_REQ.
          ptr_d   = {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
        timeout_d = expire & ~owner_done;
`endif
      end
      default: state_d = ARB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ARB_STATE_IDLE;
      ptr_q     <= PTR_RESET[NUM_REQ-1:0];
      grant_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.Grant      = grant_q;
  assign bus.GrantIndex = idx_q;
  assign bus.GrantValid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.Timeout    = timeout_q;
`else
  assign bus.Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_request_encoder.sv
// Bench for rr_request_encoder: a table of directed vectors, a watchdog
// sequence when ARB_TIMEOUT_EN is defined, then a random phase against a
// behavioural model. Expectations go into a scoreboard queue when stimulus is
// driven and are compared one clock later.
module tb_rr_request_encoder;
  import rr_request_encoder_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = 3;
  localparam bit TO_ON = 1'b1;
`else
  localparam int unsigned TW = 8;
  localparam bit TO_ON = 1'b0;
`endif

  typedef struct packed {
    logic          rst;
    logic          en;
    logic [NR-1:0] req;
    logic          rel;
  } stim_t;

  typedef struct packed {
    int unsigned   id;
    logic [NR-1:0] grant;
    logic [IW-1:0] idx;
    logic          valid;
    logic          to;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_request_encoder_if #(.NUM_REQ(NR), .IDX_WIDTH(IW)) bus ();

  rr_request_encoder #(
    .NUM_REQ       (NR),
    .IDX_WIDTH     (IW),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  exp_t sb[$];
  vec_t table_q[$];
  int   total = 0;
  int   bad   = 0;
  int unsigned vec_id = 0;

  // Behavioural model state.
  bit m_valid;
  int m_owner, m_ptr, m_cnt;

  function automatic stim_t mk_s(logic r, logic en, logic [NR-1:0] req, logic rel);
    stim_t s;
    s.rst = r; s.en = en; s.req = req; s.rel = rel;
    return s;
  endfunction

  function automatic exp_t mk_e(logic [NR-1:0] g, logic [IW-1:0] i, logic v, logic t);
    exp_t e;
    e.id = 0; e.grant = g; e.idx = i; e.valid = v; e.to = t;
    return e;
  endfunction

  task automatic add(logic r, logic en, logic [NR-1:0] req, logic rel,
                     logic [NR-1:0] g, logic [IW-1:0] i, logic v);
    vec_t vv;
    vv.s = mk_s(r, en, req, rel);
    vv.e = mk_e(g, i, v, 1'b0);
    table_q.push_back(vv);
  endtask

  function automatic exp_t model_step(stim_t s);
    exp_t e;
    logic [MAX_REQ-1:0] win;
    bit done, expired, to;
    to = 1'b0;
    if (s.rst) begin
      m_valid = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_valid) begin
      if (s.en && s.req != '0) begin
        win = '0;
        for (int k = NR - 1; k >= 0; k--) begin
          if (s.req[(m_ptr + k) % NR]) win = MAX_REQ'(1) << ((m_ptr + k) % NR);
        end
        m_valid = 1'b1;
        m_owner = int'(onehot_to_idx(win));
        m_cnt   = 0;
      end
    end else begin
      done    = s.rel || !s.req[m_owner];
      expired = TO_ON && (m_cnt == (1 << TW) - 1);
      if (done || expired) begin
        m_valid = 1'b0;
        m_ptr   = (m_owner + 1) % NR;
        to      = expired && !done;
      end else begin
        m_cnt++;
      end
    end
    e = mk_e(m_valid ? NR'(1) << m_owner : '0, m_valid ? IW'(m_owner) : '0, m_valid, to);
    return e;
  endfunction

  task automatic drive(input stim_t s, input exp_t e);
    @(negedge clk);
    rst         = s.rst;
    bus.Enable  = s.en;
    bus.Request = s.req;
    bus.Release = s.rel;
    e.id        = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  // Directed step: keeps the model in step but checks the given expectation.
  task automatic step_fixed(input stim_t s, input exp_t e);
    exp_t unused;
    unused = model_step(s);
    drive(s, e);
  endtask

  task automatic check(string name, int unsigned id, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s vec%0d: got %0h want %0h", name, id, act, want);
    end
  endtask

  exp_t ce;
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      ce = sb.pop_front();
      check("grant",  ce.id, 32'(bus.Grant),      32'(ce.grant));
      check("index",  ce.id, 32'(bus.GrantIndex), 32'(ce.idx));
      check("valid",  ce.id, 32'(bus.GrantValid), 32'(ce.valid));
      check("timeout", ce.id, 32'(bus.Timeout),   32'(ce.to));
    end
  end

  initial begin
    stim_t s;
    exp_t  e;
    rst = 1'b1; bus.Enable = 1'b0; bus.Request = '0; bus.Release = 1'b0;

    // rst en req rel | grant idx valid
    add(1, 1, 4'b1111, 0, 4'b0000, 0, 0); // reset held, requests ignored
    add(1, 1, 4'b1111, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b0101, 0, 4'b0001, 0, 1); // pointer at 0
    add(0, 1, 4'b0101, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b0101, 0, 4'b0100, 2, 1); // pointer rotated to 1
    add(0, 1, 4'b0101, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b1000, 3, 1);
    add(1, 1, 4'b1111, 0, 4'b0000, 0, 0); // reset mid-grant
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1); // full rotation 0,1,2,3,0
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0010, 1, 1);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0100, 2, 1);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b1000, 3, 1);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 0, 4'b0001, 0, 1);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 0, 4'b1111, 0, 4'b0000, 0, 0); // Enable low
    add(0, 0, 4'b1111, 1, 4'b0000, 0, 0); // Release in IDLE
    add(0, 1, 4'b0000, 0, 4'b0000, 0, 0); // no requests
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 1);
    add(0, 0, 4'b0111, 0, 4'b0100, 2, 1); // others and Enable ignored
    add(0, 1, 4'b1011, 0, 4'b0000, 0, 0); // implicit release
    add(0, 1, 4'b1011, 0, 4'b1000, 3, 1);
    add(0, 1, 4'b0011, 1, 4'b0000, 0, 0); // release + drop = one release
    add(0, 1, 4'b0011, 0, 4'b0001, 0, 1);
    add(0, 1, 4'b0011, 1, 4'b0000, 0, 0);
    add(0, 1, 4'b0010, 0, 4'b0010, 1, 1);
    add(1, 1, 4'b1001, 0, 4'b0000, 0, 0); // reset while index 1 owns
    add(0, 1, 4'b1001, 0, 4'b0001, 0, 1); // pointer back at 0
    add(0, 1, 4'b1001, 1, 4'b0000, 0, 0);

    foreach (table_q[i]) step_fixed(table_q[i].s, table_q[i].e);

`ifdef ARB_TIMEOUT_EN
    // Watchdog expiry: grant, 7 held cycles, forced release with Timeout.
    step_fixed(mk_s(0, 1, 4'b0010, 0), mk_e(4'b0010, 1, 1, 0));
    for (int k = 0; k < 7; k++) step_fixed(mk_s(0, 0, 4'b0010, 0), mk_e(4'b0010, 1, 1, 0));
    step_fixed(mk_s(0, 0, 4'b0010, 0), mk_e(4'b0000, 0, 0, 1));
    step_fixed(mk_s(0, 0, 4'b0010, 0), mk_e(4'b0000, 0, 0, 0));
    // Release in the expiry cycle wins: no Timeout.
    step_fixed(mk_s(0, 1, 4'b0010, 0), mk_e(4'b0010, 1, 1, 0));
    for (int k = 0; k < 7; k++) step_fixed(mk_s(0, 0, 4'b0010, 0), mk_e(4'b0010, 1, 1, 0));
    step_fixed(mk_s(0, 0, 4'b0010, 1), mk_e(4'b0000, 0, 0, 0));
`endif

    // Random phase against the model.
    for (int n = 0; n < 400; n++) begin
      s.rst = (n == 0) || ($urandom_range(63) == 0);
      s.en  = ($urandom_range(3) != 0);
      s.req = NR'($urandom_range(15));
      s.rel = ($urandom_range(3) == 0);
      e = model_step(s);
      drive(s, e);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
